// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: access size codes,
// controller state encoding and a word-index width helper.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // log2 of a power-of-two word count; sizes the word index.
    function automatic int dmem_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RISC-V load/store sizing: store byte enables and
// replicated write data, load extraction with sign/zero extension, and the
// misalignment flag. Purely combinational.
// Optional: DMEM_ALIGN_CHECK_EN reports misaligned half/word accesses;
// without it, misaligned addresses are rounded down to natural alignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    // Pick the effective lane, then derive enables, write data and load data.
    always_comb begin
        lane    = addr_lo_i;
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
        misalign_o = ((size_i == SZ_H) && addr_lo_i[0]) ||
                     ((size_i == SZ_W) && (addr_lo_i != 2'b00));
`else
        misalign_o = 1'b0;
`endif
        case (size_i)
            SZ_H:    lane = {addr_lo_i[1], 1'b0};
            SZ_W:    lane = 2'b00;
            default: lane = addr_lo_i;
        endcase
        shifted = rword_i >> {lane, 3'b000};
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << lane;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be_o    = 4'b0011 << lane;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_hs_ctrl.sv
// Byte-addressable data memory behind a valid/ready request port.
// IDLE accepts a request, BUSY counts LATENCY wait states and then performs
// the access, RESP drives a one-cycle response pulse. No response backpressure.
// Optional: DMEM_ALIGN_CHECK_EN (see dmem_lane_align) turns misaligned
// half/word accesses into errors.
module dmem_hs_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW   = dmem_log2(DEPTH_WORDS);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   ld_data;
    logic          misalign;
    logic          oor;
    logic          err;

    assign widx = addr_q[AW+1:2];
    assign oor  = |addr_q[31:AW+2];
    assign err  = oor || (size_q == 2'b11) || misalign;

    dmem_lane_align u_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rword_i    (mem_q[widx]),
        .be_o       (be),
        .wdata_o    (wdata_rep),
        .rdata_o    (ld_data),
        .misalign_o (misalign)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Request FSM, wait-state counter, array write and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'h0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= LAT4;
                        req_ready_q <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'h0) begin
                        cnt_q <= cnt_q - 4'h1;
                    end else begin
                        if (we_q && !err) begin
                            for (int b = 0; b < 4; b++)
                                if (be[b]) mem_q[widx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
                        end
                        rsp_rdata_q <= (we_q || err) ? 32'h0 : ld_data;
                        rsp_err_q   <= err;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
